hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: load-use / memory-wait / redirect control, stall counter and operand forwarding.
// Define HAZ_FWD_EN to forward MEM/WB results; without it every RAW match against EX/MEM/WB stalls.
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  id_opcode,
    input  logic [4:0]  id_rs1_addr,
    input  logic [4:0]  id_rs2_addr,
    input  logic [4:0]  ex_rd_addr,
    input  logic        ex_reg_write,
    input  logic        ex_is_load,
    input  logic [4:0]  mem_rd_addr,
    input  logic        mem_reg_write,
    input  logic [4:0]  wb_rd_addr,
    input  logic        wb_reg_write,
    input  logic        ex_branch_taken,
    input  logic        im_stall,
    input  logic        dm_stall,
    output logic        pc_stall,
    output logic        ifid_stall,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_stall,
    output logic [1:0]  fwd_a_sel,
    output logic [1:0]  fwd_b_sel,
    output logic [15:0] stall_cnt
);
    localparam int unsigned OP_W   = 7;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned CNT_W  = 16;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_LU_STALL = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT = 2'd2;
    localparam logic [1:0] ST_REDIR    = 2'd3;

    localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OP_W-1:0] OP_AUIPC  = 7'b0010111;
    localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OP_W-1:0] OP_RTYPE  = 7'b0110011;
    localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] FWD_RF = 2'b00;

    logic [1:0]       state_q, state_d;
    logic             pend_q, pend_d, pend_set;
    logic [CNT_W-1:0] cnt_q;
    logic             rs1_used, rs2_used;
    logic             ex_hit, mem_hit_a, mem_hit_b, wb_hit_a, wb_hit_b;
    logic             load_use, raw_stall;
    logic             stall_req, mem_hold, flush_if, flush_ex;

    // x0 never matches; a source only counts when the opcode actually reads it
    function automatic logic reg_hit(input logic used, input logic [REG_AW-1:0] rs,
                                     input logic wen, input logic [REG_AW-1:0] rd);
        return used && wen && (rs != '0) && (rs == rd);
    endfunction

    always_comb begin
        rs1_used  = (id_opcode != OP_LUI) && (id_opcode != OP_AUIPC) && (id_opcode != OP_JAL);
        rs2_used  = (id_opcode == OP_RTYPE) || (id_opcode == OP_STORE) || (id_opcode == OP_BRANCH);
        ex_hit    = reg_hit(rs1_used, id_rs1_addr, ex_reg_write, ex_rd_addr)
                 || reg_hit(rs2_used, id_rs2_addr, ex_reg_write, ex_rd_addr);
        mem_hit_a = reg_hit(rs1_used, id_rs1_addr, mem_reg_write, mem_rd_addr);
        mem_hit_b = reg_hit(rs2_used, id_rs2_addr, mem_reg_write, mem_rd_addr);
        wb_hit_a  = reg_hit(rs1_used, id_rs1_addr, wb_reg_write, wb_rd_addr);
        wb_hit_b  = reg_hit(rs2_used, id_rs2_addr, wb_reg_write, wb_rd_addr);
        load_use  = ex_is_load && ex_hit;
    end

`ifdef HAZ_FWD_EN
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    assign raw_stall = 1'b0;

    // MEM is the younger producer, so it wins over WB
    always_comb begin
        fwd_a_sel = FWD_RF;
        fwd_b_sel = FWD_RF;
        if (rst && mem_hit_a)     fwd_a_sel = FWD_MEM;
        else if (rst && wb_hit_a) fwd_a_sel = FWD_WB;
        if (rst && mem_hit_b)     fwd_b_sel = FWD_MEM;
        else if (rst && wb_hit_b) fwd_b_sel = FWD_WB;
    end
`else
    assign raw_stall = ex_hit || mem_hit_a || mem_hit_b || wb_hit_a || wb_hit_b;
    assign fwd_a_sel = FWD_RF;
    assign fwd_b_sel = FWD_RF;
`endif

    // Next state and pipeline controls; a data-memory wait overrides everything else
    always_comb begin
        state_d   = state_q;
        pend_set  = 1'b0;
        stall_req = 1'b0;
        mem_hold  = 1'b0;
        flush_if  = 1'b0;
        flush_ex  = 1'b0;
        if (dm_stall) begin
            mem_hold = 1'b1;
            state_d  = ST_MEM_WAIT;
        end else begin
            flush_if = pend_q;
            case (state_q)
                ST_RUN: begin
                    if (ex_branch_taken) begin
                        flush_ex = 1'b1;
                        if (im_stall) begin
                            state_d  = ST_REDIR;
                            pend_set = 1'b1;
                        end else begin
                            flush_if = 1'b1;
                        end
                    end else if (load_use) begin
                        stall_req = 1'b1;
                        flush_ex  = 1'b1;
                        state_d   = ST_LU_STALL;
                    end else if (raw_stall) begin
                        stall_req = 1'b1;
                        flush_ex  = 1'b1;
                    end
                end
                ST_LU_STALL: begin
                    stall_req = 1'b1;
                    flush_ex  = 1'b1;
                    state_d   = ST_RUN;
                end
                ST_MEM_WAIT: begin
                    state_d = ST_RUN;
                    if (raw_stall) begin
                        stall_req = 1'b1;
                        flush_ex  = 1'b1;
                    end
                end
                ST_REDIR: begin
                    flush_if = 1'b1;
                    if (!im_stall) state_d = ST_RUN;
                end
                default: state_d = ST_RUN;
            endcase
        end
        pend_d = pend_set || (pend_q && !flush_if);
    end

    // Everything is forced low while reset is held
    always_comb begin
        pc_stall    = rst && (stall_req || mem_hold);
        ifid_stall  = rst && (stall_req || mem_hold) && !flush_if;
        ifid_flush  = rst && flush_if;
        idex_flush  = rst && flush_ex;
        exmem_stall = rst && mem_hold;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            pend_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            if (pc_stall && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt = cnt_q;
endmodule
